// File: rtl/yabot_pkg.sv
// Shared frame layout, command IDs and FSM state type for the Jetson SPI link.
// Frame on the wire: {id[3:0], data[27:0]}, MSB first.
package yabot_pkg;

  localparam int FRAME_W = 32;
  localparam int ID_W    = 4;
  localparam int DATA_W  = 28;
  localparam int CNT_W   = 6;

  localparam logic [CNT_W-1:0] CNT_FULL = 6'd32;
  localparam logic [CNT_W-1:0] CNT_SAT  = 6'd33;

  localparam logic [ID_W-1:0] ID_Nop        = 4'd0;
  localparam logic [ID_W-1:0] ID_Sonars     = 4'd1;
  localparam logic [ID_W-1:0] ID_Motor      = 4'd2;
  localparam logic [ID_W-1:0] ID_ADC        = 4'd3;
  localparam logic [ID_W-1:0] ID_Radio      = 4'd4;
  localparam logic [ID_W-1:0] ID_RemoteCtrl = 4'd5;
  localparam logic [ID_W-1:0] ID_Servo      = 4'd13;
  localparam logic [ID_W-1:0] ID_OutGPIO    = 4'd14;
  localparam logic [ID_W-1:0] ID_PowerOff   = 4'd15;

  localparam logic [DATA_W-1:0] IDLE_PAYLOAD = 28'hB00_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } jspi_state_e;

endpackage

// File: rtl/jspi_tx_fifo.sv
// Synchronous show-ahead FIFO for reply frames.
// data_o always presents the head; a push while full is dropped.
module jspi_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok}
                     - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/jetson_spi_slave.sv
// SPI mode-0 slave to the Jetson: 32-bit frames, reply FIFO, abort detection.
// Define JSPI_FRAME_ERR_EN to enable the frame_err pulse and err_count.
module jetson_spi_slave
  import yabot_pkg::*;
#(
  parameter int                FIFO_DEPTH = 8,
  parameter logic [DATA_W-1:0] IDLE_DATA  = IDLE_PAYLOAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic              rx_valid,
  output logic [ID_W-1:0]   rx_id,
  output logic [DATA_W-1:0] rx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [ID_W-1:0]   tx_id,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_pending,
  output logic              frame_err,
  output logic [7:0]        err_count
);

  jspi_state_e        state_q;
  logic [2:0]         cs_q;
  logic [2:0]         sck_q;
  logic [1:0]         mosi_q;
  logic [FRAME_W-1:0] tx_sr_q;
  logic [FRAME_W-1:0] rx_sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               loaded_q;
  logic               pop_q;
  logic               miso_q;
  logic               rx_valid_q;
  logic [ID_W-1:0]    rx_id_q;
  logic [DATA_W-1:0]  rx_data_q;
  logic [FRAME_W-1:0] fifo_head;
  logic [FRAME_W-1:0] load_d;
  logic               fifo_empty;
  logic               fifo_full;
  logic               cs_hi;
  logic               cs_fall;
  logic               sck_rise;
  logic               sck_fall;

  jspi_tx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .data_i  ({tx_id, tx_data}),
    .pop_i   (pop_q),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // bit 0 = first sync stage, bit 1 = synchronized, bit 2 = previous
  assign cs_hi    = cs_q[1];
  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign load_d   = fifo_empty ? {ID_Nop, IDLE_DATA} : fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs};
      sck_q  <= {sck_q[1:0], spi_clk};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

`ifdef JSPI_FRAME_ERR_EN
  logic       frame_err_q;
  logic [7:0] err_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      loaded_q   <= 1'b0;
      pop_q      <= 1'b0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_id_q    <= '0;
      rx_data_q  <= '0;
`ifdef JSPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      pop_q      <= 1'b0;
`ifdef JSPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (cs_hi) begin
            state_q <= S_IDLE;
          end else begin
            tx_sr_q  <= load_d;
            loaded_q <= !fifo_empty;
            miso_q   <= load_d[FRAME_W-1];
            cnt_q    <= '0;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cs_hi) begin
            miso_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            if (sck_rise) begin
              rx_sr_q <= {rx_sr_q[FRAME_W-2:0], mosi_q[1]};
              cnt_q   <= (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 1'b1;
            end
            if (sck_fall) begin
              tx_sr_q <= {tx_sr_q[FRAME_W-2:0], 1'b0};
              miso_q  <= tx_sr_q[FRAME_W-2];
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (cnt_q == CNT_FULL) begin
            rx_valid_q <= 1'b1;
            rx_id_q    <= rx_sr_q[FRAME_W-1 -: ID_W];
            rx_data_q  <= rx_sr_q[DATA_W-1:0];
            pop_q      <= loaded_q;
          end else begin
`ifdef JSPI_FRAME_ERR_EN
            frame_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // raw cs gate keeps MISO quiet before the synchronizer catches up
  assign spi_miso   = miso_q & ~spi_cs;
  assign rx_valid   = rx_valid_q;
  assign rx_id      = rx_id_q;
  assign rx_data    = rx_data_q;
  assign tx_ready   = !fifo_full;
  assign tx_pending = !fifo_empty;

`ifdef JSPI_FRAME_ERR_EN
  assign frame_err = frame_err_q;
  assign err_count = err_cnt_q;
`else
  assign frame_err = 1'b0;
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/jetson_spi_slave.md
JETSON_SPI_SLAVE -- requirements
Module: jetson_spi_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set the TX FIFO depth (power of two, 2..32).
REQ-002 Parameter IDLE_DATA, default 28'hB00_0000, SHALL set the data field sent when the TX FIFO is empty.
REQ-003 Ports SHALL be, in order:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  Jetson SPI clock, asynchronous to clk.
- spi_mosi  in  1  Jetson MOSI.
- spi_cs  in  1  Jetson chip select, active low.
- spi_miso  out  1  MISO to Jetson.
- rx_valid  out  1  one-cycle pulse, received frame valid.
- rx_id  out  4  received command ID.
- rx_data  out  28  received payload.
- tx_valid  in  1  internal producer has a reply frame.
- tx_ready  out  1  TX FIFO not full.
- tx_id  in  4  reply ID.
- tx_data  in  28  reply payload.
- tx_pending  out  1  TX FIFO non-empty (Jetson attention line).
- frame_err  out  1  one-cycle pulse on an aborted frame.
- err_count  out  8  saturating aborted-frame count.

Function
REQ-004 Frame SHALL be 32 bits, MSB first, {id[3:0], data[27:0]}, SPI mode 0; Jetson samples MISO on rising spi_clk.
REQ-005 spi_clk, spi_mosi and spi_cs SHALL pass through 2-FF synchronizers; edges SHALL be detected in the clk domain; supported spi_clk is at most clk/8.
REQ-006 States SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-007 IDLE -> LOAD on synchronized spi_cs falling edge.
REQ-008 LOAD (1 cycle) SHALL copy the FIFO head (peek, no pop) or {4'h0, IDLE_DATA} when empty into the TX shift register, drive bit 31 on spi_miso, clear the bit counter, then go to SHIFT.
REQ-009 SHIFT: each rising spi_clk SHALL shift spi_mosi into the RX register and increment the counter; each falling spi_clk SHALL advance spi_miso to the next TX bit.
REQ-010 SHIFT -> DONE on spi_cs rising edge.
REQ-011 DONE with counter == 32: one cycle later assert rx_valid for 1 cycle with rx_id/rx_data, pop the FIFO only if a FIFO frame was loaded, return to IDLE.
REQ-012 DONE with counter != 32: no rx_valid, no pop, assert frame_err for 1 cycle, return to IDLE.
REQ-013 Counter SHALL saturate at 33; more than 32 clocks counts as aborted.
REQ-014 rx_id/rx_data SHALL hold their value until the next valid frame.
REQ-015 FIFO push occurs when tx_valid && tx_ready; tx_ready = !full; a push while full SHALL be ignored.
REQ-016 Same-cycle push and pop SHALL keep occupancy unchanged; push on empty during LOAD SHALL NOT affect the frame already loaded.
REQ-017 spi_miso SHALL be 0 whenever spi_cs is deasserted.
REQ-018 spi_cs deasserted in any state SHALL return the FSM to IDLE within 3 clk cycles.

Reset
REQ-019 On rst_n low: FSM IDLE, FIFO empty, spi_miso 0, rx_valid 0, rx_id 0, rx_data 0, tx_ready 1, tx_pending 0, frame_err 0, err_count 0, synchronizers set to cs=1 and clk=0.
REQ-020 Reset mid-frame SHALL discard the frame with no rx_valid and no frame_err.

Configuration
REQ-021 Macro JSPI_FRAME_ERR_EN defined: frame_err and err_count SHALL operate per REQ-012 (err_count saturates at 255).
REQ-022 Macro JSPI_FRAME_ERR_EN undefined: frame_err and err_count SHALL be tied to 0; aborted frames are still discarded silently.

Structure
REQ-023 yabot_pkg SHALL hold the frame width (32), ID width (4), data width (28), the ID_* command constants (Nop=0, Sonars=1, Motor=2, ADC=3, Radio=4, RemoteCtrl=5, Servo=13, OutGPIO=14, PowerOff=15) and the default idle payload.
REQ-024 The TX FIFO SHALL be the sub-module jspi_tx_fifo (synchronous, show-ahead, parameterized width and depth).

Verification
REQ-025 Jetson sends {ID_OutGPIO, 28'h1} with the FIFO empty -> rx_valid once, rx_id=14, rx_data=1; MISO returns 32'h0B00_0000.
REQ-026 Push {ID_ADC, 28'h002_0005} then Jetson sends Nop -> MISO 32'h3002_0005, tx_pending drops after DONE; next frame returns the idle frame.
REQ-027 Push 8 frames -> tx_ready=0; 9th push ignored; 8 reads return the frames in order, then the idle frame.
REQ-028 cs raised after 17 bits with {ID_Sonars,...} queued -> no rx_valid, frame_err pulse, err_count=1; next full frame returns the same Sonars reply.
REQ-029 rst_n asserted after 10 bits -> all outputs at reset values; a following full frame {ID_PowerOff, 2} is received correctly.
REQ-030 Build without JSPI_FRAME_ERR_EN, rerun REQ-028 -> frame_err and err_count stay 0; the reply is still retained.
